// File: rtl/lc3_mmio_ctrl_if.sv
// Bus-side access port of the LC-3 MMIO controller.
// The datapath drives MAR/MDR/strobe and gets back hit, read data and completion.
interface lc3_mmio_ctrl_if;
   logic [15:0] i_Addr;
   logic [15:0] i_Wdata;
   logic        i_Mem_En;
   logic        i_RW;
   logic        o_Hit;
   logic [15:0] o_Rdata;
   logic        o_R;

   modport slave (
      input  i_Addr, i_Wdata, i_Mem_En, i_RW,
      output o_Hit, o_Rdata, o_R
   );

   modport master (
      output i_Addr, i_Wdata, i_Mem_En, i_RW,
      input  o_Hit, o_Rdata, o_R
   );
endinterface

// File: rtl/lc3_mmio_ctrl.sv
// Multi-channel LC-3 MMIO controller: per-channel RX FIFO with overflow flag,
// TX holding register with valid/ready handshake, and a combined interrupt.
module lc3_mmio_ctrl #(
   parameter int          NUM_CH    = 2,
   parameter int          RX_DEPTH  = 4,
   parameter logic [15:0] BASE_ADDR = 16'hFE00,
   parameter int          CH_STRIDE = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   lc3_mmio_ctrl_if.slave        bus,
   input  logic [NUM_CH-1:0]     i_Rx_Valid,
   input  logic [8*NUM_CH-1:0]   i_Rx_Data,
   output logic [NUM_CH-1:0]     o_Tx_Valid,
   output logic [8*NUM_CH-1:0]   o_Tx_Data,
   input  logic [NUM_CH-1:0]     i_Tx_Ready,
   output logic                  o_Irq
);

   localparam int PW = $clog2(RX_DEPTH);
   localparam int CW = PW + 1;

   logic [NUM_CH-1:0] w_sel;
   logic [NUM_CH-1:0] w_irq_src;
   logic [15:0]       w_rdv [NUM_CH];
   logic [15:0]       w_rdata;
   logic              w_acc;
   logic [15:0]       r_rdata;
   logic              r_r;
   logic              r_irq;
   logic              w_unused;

   assign w_unused    = ^{bus.i_Wdata[15], bus.i_Wdata[12:8]};
   assign bus.o_Hit   = |w_sel;
   assign w_acc       = bus.i_Mem_En & bus.o_Hit;
   assign bus.o_Rdata = r_rdata;
   assign bus.o_R     = r_r;
   assign o_Irq       = r_irq;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [15:0] CH_BASE = BASE_ADDR + 16'(c * CH_STRIDE);

      logic [7:0]    r_mem [RX_DEPTH];
      logic [PW-1:0] r_wp;
      logic [PW-1:0] r_rp;
      logic [CW-1:0] r_cnt;
      logic          r_ovf;
      logic          r_rxie;
      logic          r_txie;
      logic          r_txv;
      logic [7:0]    r_txd;
      logic [15:0]   w_diff;
      logic [1:0]    w_off;
      logic          w_wr, w_rd, w_empty, w_full, w_pop, w_push, w_ovf_set, w_tx_load;
      logic [15:0]   w_rd_val;

      // Offset from this channel's base; the 4-register window is diff < 4.
      assign w_diff    = bus.i_Addr - CH_BASE;
      assign w_sel[c]  = (w_diff[15:2] == 14'd0);
      assign w_off     = w_diff[1:0];
      assign w_wr      = bus.i_Mem_En & w_sel[c] & bus.i_RW;
      assign w_rd      = bus.i_Mem_En & w_sel[c] & ~bus.i_RW;
      assign w_empty   = (r_cnt == CW'(0));
      assign w_full    = (r_cnt == CW'(RX_DEPTH));
      assign w_pop     = w_rd & (w_off == 2'd1) & ~w_empty;
      // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
      assign w_push    = i_Rx_Valid[c] & (~w_full | w_pop);
      assign w_ovf_set = i_Rx_Valid[c] & w_full & ~w_pop;
      assign w_tx_load = w_wr & (w_off == 2'd3) & ~r_txv;

      // Read value of the addressed register within this channel.
      always_comb begin
         case (w_off)
            2'd0:    w_rd_val = {~w_empty, r_rxie, r_ovf, 13'd0};
            2'd1:    w_rd_val = w_empty ? 16'h0000 : {8'h00, r_mem[r_rp]};
            2'd2:    w_rd_val = {~r_txv, r_txie, 14'd0};
            default: w_rd_val = 16'h0000;
         endcase
      end

      assign w_rdv[c]     = w_sel[c] ? w_rd_val : 16'h0000;
      assign w_irq_src[c] = (~w_empty & r_rxie) | (~r_txv & r_txie);
      assign o_Tx_Valid[c]      = r_txv;
      assign o_Tx_Data[8*c +: 8] = r_txd;

      // FIFO storage; contents are don't-care while the count says empty.
      always_ff @(posedge i_Clk) begin
         if (w_push) begin
            r_mem[r_wp] <= i_Rx_Data[8*c +: 8];
         end
      end

      // Channel control state: pointers, count, flags and TX holding register.
      always_ff @(posedge i_Clk or posedge i_Rst) begin
         if (i_Rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_rxie <= 1'b0;
            r_txie <= 1'b0;
            r_txv  <= 1'b0;
            r_txd  <= 8'h00;
         end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            case ({w_push, w_pop})
               2'b10:   r_cnt <= r_cnt + CW'(1);
               2'b01:   r_cnt <= r_cnt - CW'(1);
               default: r_cnt <= r_cnt;
            endcase
            if (w_wr && w_off == 2'd0) r_rxie <= bus.i_Wdata[14];
            if (w_wr && w_off == 2'd2) r_txie <= bus.i_Wdata[14];
            // A new overflow in the same cycle as a clear keeps the flag set.
            if (w_ovf_set) begin
               r_ovf <= 1'b1;
            end else if (w_wr && w_off == 2'd0 && bus.i_Wdata[13]) begin
               r_ovf <= 1'b0;
            end
            if (w_tx_load) begin
               r_txv <= 1'b1;
               r_txd <= bus.i_Wdata[7:0];
            end else if (r_txv && i_Tx_Ready[c]) begin
               r_txv <= 1'b0;
            end
         end
      end
   end

   // Channel windows never overlap, so OR-ing the gated values selects one.
   always_comb begin
      w_rdata = 16'h0000;
      for (int c = 0; c < NUM_CH; c++) begin
         w_rdata = w_rdata | w_rdv[c];
      end
   end

   // Access completion, read data capture and interrupt register.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_rdata <= 16'h0000;
         r_r     <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_r   <= w_acc;
         r_irq <= |w_irq_src;
         if (w_acc && !bus.i_RW) r_rdata <= w_rdata;
      end
   end

endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// Randomized and directed bench for lc3_mmio_ctrl against a queue-based
// model of the register map, FIFOs and TX handshake.
module tb_lc3_mmio_ctrl;
   localparam int          NUM_CH    = 2;
   localparam int          RX_DEPTH  = 4;
   localparam logic [15:0] BASE_ADDR = 16'hFE00;
   localparam int          CH_STRIDE = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NUM_CH-1:0]    rx_valid = '0;
   logic [8*NUM_CH-1:0]  rx_data = '0;
   logic [NUM_CH-1:0]    tx_valid;
   logic [8*NUM_CH-1:0]  tx_data;
   logic [NUM_CH-1:0]    tx_ready = '0;
   logic                 irq;

   lc3_mmio_ctrl_if bif ();

   lc3_mmio_ctrl #(
      .NUM_CH(NUM_CH), .RX_DEPTH(RX_DEPTH), .BASE_ADDR(BASE_ADDR), .CH_STRIDE(CH_STRIDE)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .bus(bif),
      .i_Rx_Valid(rx_valid), .i_Rx_Data(rx_data),
      .o_Tx_Valid(tx_valid), .o_Tx_Data(tx_data),
      .i_Tx_Ready(tx_ready), .o_Irq(irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]          m_q [NUM_CH][$];
   logic [NUM_CH-1:0]   m_ovf, m_rxie, m_txie, m_txv;
   logic [8*NUM_CH-1:0] m_txd;
   logic [15:0]         m_rdata;
   logic                m_r, m_irq;
   logic [NUM_CH-1:0]   g_txr = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_hit(input logic [15:0] a, output int ch, output int off);
      int d;
      d   = int'(a) - int'(BASE_ADDR);
      ch  = 0;
      off = 0;
      if (d < 0) return 1'b0;
      ch  = d / CH_STRIDE;
      off = d % CH_STRIDE;
      return (ch < NUM_CH) && (off < 4);
   endfunction

   task automatic m_reset();
      for (int c = 0; c < NUM_CH; c++) m_q[c].delete();
      m_ovf = '0; m_rxie = '0; m_txie = '0; m_txv = '0; m_txd = '0;
      m_rdata = 16'h0000; m_r = 1'b0; m_irq = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs of that cycle.
   task automatic m_edge(input logic en, input logic rw, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [NUM_CH-1:0] rxv,
                         input logic [8*NUM_CH-1:0] rxd, input logic [NUM_CH-1:0] txr);
      int ch, off;
      bit h, load;
      logic [15:0] rv;
      logic irq_n;
      irq_n = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         irq_n |= ((m_q[c].size() > 0) && m_rxie[c]) || (!m_txv[c] && m_txie[c]);
      h    = m_hit(addr, ch, off);
      rv   = 16'h0000;
      load = en && h && rw && off == 3 && !m_txv[ch];
      if (en && h && !rw) begin
         case (off)
            0: rv = {m_q[ch].size() > 0, m_rxie[ch], m_ovf[ch], 13'd0};
            1: if (m_q[ch].size() > 0) rv = {8'h00, m_q[ch].pop_front()};
            2: rv = {!m_txv[ch], m_txie[ch], 14'd0};
            default: rv = 16'h0000;
         endcase
      end else if (en && h && rw) begin
         if (off == 0) begin
            m_rxie[ch] = wd[14];
            if (wd[13]) m_ovf[ch] = 1'b0;
         end
         if (off == 2) m_txie[ch] = wd[14];
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (rxv[c]) begin
            if (m_q[c].size() < RX_DEPTH) m_q[c].push_back(rxd[8*c +: 8]);
            else m_ovf[c] = 1'b1;
         end
         if (load && c == ch) begin
            m_txv[c] = 1'b1;
            m_txd[8*c +: 8] = wd[7:0];
         end else if (m_txv[c] && txr[c]) begin
            m_txv[c] = 1'b0;
         end
      end
      m_r = en && h;
      if (en && h && !rw) m_rdata = rv;
      m_irq = irq_n;
   endtask

   // One bus cycle: drive at edge+1, check hit, then check outputs after the edge.
   task automatic cyc(input logic en, input logic rw, input logic [15:0] addr,
                      input logic [15:0] wd, input logic [NUM_CH-1:0] rxv,
                      input logic [8*NUM_CH-1:0] rxd);
      int ch, off;
      bit h;
      bif.i_Mem_En = en; bif.i_RW = rw; bif.i_Addr = addr; bif.i_Wdata = wd;
      rx_valid = rxv; rx_data = rxd; tx_ready = g_txr;
      #1;
      h = m_hit(addr, ch, off);
      chk("hit", bif.o_Hit, h);
      @(posedge clk);
      m_edge(en, rw, addr, wd, rxv, rxd, g_txr);
      #1;
      chk("r", bif.o_R, m_r);
      chk("rdata", bif.o_Rdata, m_rdata);
      chk("txv", tx_valid, m_txv);
      chk("txd", tx_data, m_txd);
      chk("irq", irq, m_irq);
   endtask

   task automatic rd(input logic [15:0] a);
      cyc(1'b1, 1'b0, a, 16'h0000, '0, '0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      cyc(1'b1, 1'b1, a, d, '0, '0);
   endtask

   task automatic push(input int ch, input logic [7:0] b);
      logic [NUM_CH-1:0]   v;
      logic [8*NUM_CH-1:0] d;
      v = '0; d = '0;
      v[ch] = 1'b1;
      d[8*ch +: 8] = b;
      cyc(1'b0, 1'b0, 16'h0000, 16'h0000, v, d);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 16'h0000, 16'h0000, '0, '0);
   endtask

   initial begin
      logic [15:0] a;
      int pick;
      bif.i_Mem_En = 1'b0; bif.i_RW = 1'b0; bif.i_Addr = 16'h0000; bif.i_Wdata = 16'h0000;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdata", bif.o_Rdata, 16'h0000);
      chk("rst_r", bif.o_R, 1'b0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_txv", tx_valid, '0);
      rst = 1'b0;

      rd(16'hFE00); chk("rxsr_empty", bif.o_Rdata, 16'h0000); idle();
      rd(16'hFE02); chk("txsr_idle", bif.o_Rdata, 16'h8000); idle();
      rd(16'hFE01); chk("rxdr_empty", bif.o_Rdata, 16'h0000); idle();

      push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
      rd(16'hFE00); chk("rxsr_ne", bif.o_Rdata, 16'h8000);
      rd(16'hFE01); chk("pop1", bif.o_Rdata, 16'h0011);
      rd(16'hFE01); rd(16'hFE01);
      rd(16'hFE01); chk("pop4", bif.o_Rdata, 16'h0044);
      rd(16'hFE00); chk("rxsr_drained", bif.o_Rdata, 16'h0000);

      for (int i = 0; i < 5; i++) push(1, 8'(8'h51 + i));
      rd(16'hFE04); chk("ovf_set", bif.o_Rdata, 16'hA000);
      wr(16'hFE04, 16'h2000);
      rd(16'hFE04); chk("ovf_clr", bif.o_Rdata, 16'h8000);
      for (int i = 0; i < 4; i++) rd(16'hFE05);
      chk("ch1_last", bif.o_Rdata, 16'h0054);

      for (int i = 1; i <= 4; i++) push(0, 8'(i));
      cyc(1'b1, 1'b0, 16'hFE01, 16'h0000, 2'b01, 16'h0066);
      chk("full_popush", bif.o_Rdata, 16'h0001);
      rd(16'hFE00); chk("no_ovf", bif.o_Rdata, 16'h8000);
      for (int i = 0; i < 4; i++) rd(16'hFE01);
      chk("tail66", bif.o_Rdata, 16'h0066);

      g_txr = '0;
      wr(16'hFE03, 16'h0041); idle();
      wr(16'hFE03, 16'h0042); idle();
      chk("tx_hold", tx_data[7:0], 8'h41);
      rd(16'hFE02); chk("txsr_busy", bif.o_Rdata, 16'h0000);
      g_txr = 2'b01; idle(); g_txr = '0;
      chk("tx_done", tx_valid[0], 1'b0);
      rd(16'hFE02); chk("txsr_ready", bif.o_Rdata, 16'h8000);

      wr(16'hFE02, 16'h4000);
      chk("irq_lat1", irq, 1'b0);
      idle();
      chk("irq_lat2", irq, 1'b1);
      wr(16'hFE00, 16'h4000);
      push(0, 8'h9A);
      wr(16'hFE03, 16'h0077); idle();
      chk("irq_rx", irq, 1'b1);
      chk("tx_busy", tx_valid[0], 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_txv", tx_valid, '0);
      chk("arst_irq", irq, 1'b0);
      m_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 600; i++) begin
         pick = $urandom_range(0, 9);
         if (pick < 8)       a = BASE_ADDR + 16'(pick);
         else if (pick == 8) a = BASE_ADDR + 16'(NUM_CH * CH_STRIDE);
         else                a = 16'($urandom);
         g_txr = NUM_CH'($urandom);
         cyc(1'($urandom), 1'($urandom), a, 16'($urandom),
             ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0, (8*NUM_CH)'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
